// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and defaults for the multiply/divide scheduler.
// Optional macro MDU_MADD_EN widens md_op to 4 bits and adds MADD/MADDU/MSUB/MSUBU.
package mdu_pkg;

`ifdef MDU_MADD_EN
    localparam int OP_W = 4;
`else
    localparam int OP_W = 3;
`endif

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Code 7 is reserved and behaves like OP_NONE wherever it appears.
    typedef enum logic [OP_W-1:0] {
        OP_NONE  = OP_W'(0),
        OP_MULT  = OP_W'(1),
        OP_MULTU = OP_W'(2),
        OP_DIV   = OP_W'(3),
        OP_DIVU  = OP_W'(4),
        OP_MTHI  = OP_W'(5),
        OP_MTLO  = OP_W'(6)
`ifdef MDU_MADD_EN
        ,
        OP_MADD  = OP_W'(8),
        OP_MADDU = OP_W'(9),
        OP_MSUB  = OP_W'(10),
        OP_MSUBU = OP_W'(11)
`endif
    } md_op_t;

    typedef enum logic {IDLE, RUN} state_t;

    // True for every op that occupies the unit for several cycles.
    function automatic logic is_multi(input md_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result generator for a multi-cycle MDU op.
// One shared multiplier and one shared divider serve signed and unsigned forms.
// Optional macro MDU_MADD_EN adds accumulate/subtract into the current HI/LO.
module mdu_calc
    import mdu_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] pending_hi,
    output logic [31:0] pending_lo,
    output logic        div0
);

    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed division works on magnitudes; quotient sign is the xor of the
    // operand signs and the remainder follows the dividend.
    always_comb begin
        sgn = (op == OP_MULT) || (op == OP_DIV)
`ifdef MDU_MADD_EN
              || (op == OP_MADD) || (op == OP_MSUB)
`endif
              ;
        ext_a = sgn ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        ext_b = sgn ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        prod  = ext_a * ext_b;

        dvd   = (sgn && src_a[31]) ? -src_a : src_a;
        dvs   = (sgn && src_b[31]) ? -src_b : src_b;
        if (dvs == 32'd0) begin
            dvs = 32'd1;
        end
        q_mag = dvd / dvs;
        r_mag = dvd % dvs;
        quo   = (sgn && (src_a[31] ^ src_b[31])) ? -q_mag : q_mag;
        rem   = (sgn && src_a[31]) ? -r_mag : r_mag;

        div0  = is_div(op) && (src_b == 32'd0);

        {pending_hi, pending_lo} = {hi, lo};
        case (op)
            OP_MULT, OP_MULTU: {pending_hi, pending_lo} = prod;
            OP_DIV, OP_DIVU:   {pending_hi, pending_lo} = {rem, quo};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: {pending_hi, pending_lo} = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: {pending_hi, pending_lo} = {hi, lo} - prod;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: E-stage multiply/divide sequencer owning HI/LO.
// Multi-cycle ops latch their result at start and commit it after a busy countdown.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (4-bit md_op).
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            md_start,
    input  logic [OP_W-1:0] md_op,
    input  logic [31:0]     src_a,
    input  logic [31:0]     src_b,
    input  logic            d_md_use,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic            busy,
    output logic            stall_md
);

    md_op_t            op;
    logic              start_multi;
    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic [31:0]       pending_hi;
    logic [31:0]       pending_lo;
    logic              pending_div0;
    logic [31:0]       calc_hi;
    logic [31:0]       calc_lo;
    logic              calc_div0;

    assign op          = md_op_t'(md_op);
    assign start_multi = md_start && is_multi(op);
    assign busy        = (state == RUN);
    assign stall_md    = d_md_use && (busy || start_multi);

    mdu_calc u_calc (
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hi         (hi),
        .lo         (lo),
        .pending_hi (calc_hi),
        .pending_lo (calc_lo),
        .div0       (calc_div0)
    );

    // Leave IDLE on a multi-cycle start; return when the countdown expires.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_multi) next_state = RUN;
            RUN:     if (count == CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // HI/LO, countdown and pending result; starts and moves only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi           <= 32'd0;
            lo           <= 32'd0;
            count        <= '0;
            pending_hi   <= 32'd0;
            pending_lo   <= 32'd0;
            pending_div0 <= 1'b0;
        end else if (state == IDLE) begin
            if (start_multi) begin
                pending_hi   <= calc_hi;
                pending_lo   <= calc_lo;
                pending_div0 <= calc_div0;
                count        <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (md_start && op == OP_MTHI) begin
                hi <= src_a;
            end else if (md_start && op == OP_MTLO) begin
                lo <= src_a;
            end
        end else begin
            if (count == CNT_W'(1)) begin
                if (!pending_div0) begin
                    hi <= pending_hi;
                    lo <= pending_lo;
                end
                count <= '0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
